tlu_data_fifo: RTL

Single-clock first-word-fall-through buffer that sits directly downstream of the TLU controller and receives its 32-bit trigger data words. It presents them to the readout arbiter through the FIFO_READ / FIFO_EMPTY / FIFO_DATA handshake. It also drives the FIFO_NEAR_FULL back-pressure signal that the TLU controller uses to stop accepting triggers. Overflowed words are dropped and counted.

---
 rtl/tlu_data_fifo.sv | 101 ++++++++++
 1 files changed

// File: rtl/tlu_data_fifo.sv
// First-word-fall-through buffer between the TLU controller and the readout arbiter.
// Optional build macro TLU_FIFO_LOST_COUNT_EN adds the saturating dropped-word counter.
module tlu_data_fifo #(
    parameter int DEPTH_BITS          = 5,
    parameter int NEAR_FULL_THRESHOLD = 24
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST,
    input  logic [31:0]           TLU_WORD_IN,
    input  logic                  TLU_WORD_VALID,
    input  logic                  FIFO_READ,
    output logic                  FIFO_EMPTY,
    output logic [31:0]           FIFO_DATA,
    output logic                  FIFO_NEAR_FULL,
    output logic [DEPTH_BITS:0]   FIFO_SIZE,
    output logic [7:0]            LOST_COUNT
);

    localparam int                  DEPTH     = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FILL_FULL = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] FILL_NF   = (DEPTH_BITS + 1)'(NEAR_FULL_THRESHOLD);
    localparam logic [DEPTH_BITS:0] FILL_ONE  = (DEPTH_BITS + 1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

    logic [31:0]           mem_reg [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_BITS-1:0] rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_BITS:0]   fill_reg, fill_next;

    logic full;
    logic empty;
    logic pop;
    logic accept;

    // Full/empty come from the fill counter so pointer equality never needs disambiguating.
    assign full   = (fill_reg == FILL_FULL);
    assign empty  = (fill_reg == '0);
    assign pop    = FIFO_READ && !empty;
    assign accept = TLU_WORD_VALID && (!full || pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        fill_next   = fill_reg;
        if (accept) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        case ({accept, pop})
            2'b10:   fill_next = fill_reg + FILL_ONE;
            2'b01:   fill_next = fill_reg - FILL_ONE;
            default: fill_next = fill_reg;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            fill_reg   <= fill_next;
        end
    end

    // Storage is never cleared; reset only invalidates it through the pointers.
    always_ff @(posedge BUS_CLK) begin
        if (accept && !BUS_RST) begin
            mem_reg[wr_ptr_reg] <= TLU_WORD_IN;
        end
    end

    assign FIFO_DATA      = mem_reg[rd_ptr_reg];
    assign FIFO_EMPTY     = empty;
    assign FIFO_NEAR_FULL = (fill_reg >= FILL_NF);
    assign FIFO_SIZE      = fill_reg;

`ifdef TLU_FIFO_LOST_COUNT_EN
    logic [7:0] lost_reg;
    logic       drop;

    assign drop = TLU_WORD_VALID && full && !pop;

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            lost_reg <= '0;
        end else if (drop && (lost_reg != 8'hFF)) begin
            lost_reg <= lost_reg + 8'd1;
        end
    end

    assign LOST_COUNT = lost_reg;
`else
    assign LOST_COUNT = '0;
`endif

endmodule
